// File: rtl/ram_pkg.sv
// Shared types and helpers for the wait-stated big-endian data RAM.
package ram_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        LEN_BYTE  = 2'b00,
        LEN_HALF  = 2'b01,
        LEN_WORD  = 2'b10,
        LEN_DWORD = 2'b11
    } len_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Latched request payload (address is kept separately, its width is a parameter).
    typedef struct packed {
        logic              rw;
        len_e              len;
        logic [DATA_W-1:0] data;
    } req_t;

    // Write payload presented to the byte array: lane 3 is the byte at the base address.
    typedef struct packed {
        logic [3:0]        lanes;
        logic [DATA_W-1:0] data;
    } wr_t;

    // Left-justify right-justified write data and pick the big-endian lanes.
    function automatic wr_t write_lanes(len_e len, logic [DATA_W-1:0] d);
        wr_t w;
        case (len)
            LEN_BYTE: begin
                w.lanes = 4'b1000;
                w.data  = {d[7:0], 24'h0};
            end
            LEN_HALF: begin
                w.lanes = 4'b1100;
                w.data  = {d[15:0], 16'h0};
            end
            default: begin
                w.lanes = 4'b1111;
                w.data  = d;
            end
        endcase
        return w;
    endfunction

    // Right-justify and zero-extend the bytes read starting at the base address.
    function automatic logic [DATA_W-1:0] read_align(len_e len, logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] r;
        case (len)
            LEN_BYTE: r = {24'h0, raw[31:24]};
            LEN_HALF: r = {16'h0, raw[31:16]};
            default:  r = raw;
        endcase
        return r;
    endfunction

    // True when the access size is not naturally aligned at this address.
    function automatic logic misaligned(len_e len, logic [1:0] lsb);
        logic m;
        case (len)
            LEN_BYTE: m = 1'b0;
            LEN_HALF: m = lsb[0];
            default:  m = (lsb != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ram_ws_if.sv
// Request/response bundle between the memory-interface control unit and the RAM.
interface ram_ws_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                          enable;
    logic                          read_write;
    logic [1:0]                    data_length;
    logic [ADDR_WIDTH-1:0]         address;
    logic [ram_pkg::DATA_W-1:0]    data_in;
    logic [ram_pkg::DATA_W-1:0]    data_out;
    logic                          mfc;
    logic                          busy;
    logic                          err;

    modport master (
        output enable, read_write, data_length, address, data_in,
        input  data_out, mfc, busy, err
    );

    modport slave (
        input  enable, read_write, data_length, address, data_in,
        output data_out, mfc, busy, err
    );
endinterface

// File: rtl/ram_byte_array.sv
// Byte-wide storage: combinational 4-byte big-endian read, lane-enabled synchronous write.
module ram_byte_array #(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [3:0]            lanes,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] lane_addr [4];

    // Byte i of the word sits at addr+i, wrapping at the top of the array.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign lane_addr[g]        = addr + ADDR_WIDTH'(g);
        assign rdata[8*(3-g) +: 8] = mem[lane_addr[g]];
    end

    // Store enabled lanes; lane 3 carries the byte at the base address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && lanes[2'(3 - i)]) begin
                mem[lane_addr[i]] <= wdata[8*(3-i) +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_ws.sv
// Clocked big-endian data RAM with WAIT_STATES extra cycles per beat and a one-cycle mfc pulse.
// Optional RAM_ALIGN_CHECK_EN: flag misaligned accesses with err and suppress their effect.
module ram_ws
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    ram_ws_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_STATES);

    state_e                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  beat, beat_next;
    logic                  load_req_c, load_beat2_c, access_c;

    req_t                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]     raw_rdata;
    wr_t                   wr_c;
    logic                  misalign_c, wr_en_c;

    logic [DATA_W-1:0]     data_out_q;
    logic                  mfc_q, busy_q, err_q;

    assign bus.data_out = data_out_q;
    assign bus.mfc      = mfc_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

`ifdef RAM_ALIGN_CHECK_EN
    assign misalign_c = misaligned(req.len, addr[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    assign wr_c    = write_lanes(req.len, req.data);
    assign wr_en_c = access_c && (req.rw == RW_WRITE) && !misalign_c;

    ram_byte_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .addr  (addr),
        .we    (wr_en_c),
        .lanes (wr_c.lanes),
        .wdata (wr_c.data),
        .rdata (raw_rdata)
    );

    // Next-state, counter and beat control.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        beat_next    = beat;
        load_req_c   = 1'b0;
        load_beat2_c = 1'b0;
        access_c     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.enable) begin
                    load_req_c = 1'b1;
                    cnt_next   = CNT_RELOAD;
                    beat_next  = 1'b0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    access_c   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A flagged first beat ends the doubleword early.
                if ((req.len == LEN_DWORD) && !beat && !err_q) begin
                    beat_next    = 1'b1;
                    load_beat2_c = 1'b1;
                    cnt_next     = CNT_RELOAD;
                    state_next   = ST_WAIT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            beat   <= 1'b0;
            mfc_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            beat   <= beat_next;
            mfc_q  <= (state_next == ST_DONE);
            busy_q <= (state_next != ST_IDLE);
        end
    end

    // Request latch; the second doubleword beat advances the address and takes fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req  <= '{rw: RW_WRITE, len: LEN_BYTE, data: '0};
            addr <= '0;
        end else if (load_req_c) begin
            req  <= '{rw: bus.read_write, len: len_e'(bus.data_length), data: bus.data_in};
            addr <= bus.address;
        end else if (load_beat2_c) begin
            req.data <= bus.data_in;
            addr     <= addr + ADDR_WIDTH'(4);
        end
    end

    // Read data only changes when a non-flagged read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else if (access_c && (req.rw == RW_READ) && !misalign_c) begin
            data_out_q <= read_align(req.len, raw_rdata);
        end
    end

`ifdef RAM_ALIGN_CHECK_EN
    // Error flag accompanies the mfc pulse of a misaligned beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access_c && misalign_c;
        end
    end
`else
    assign err_q = 1'b0;
`endif

endmodule

// File: tb/tb_ram_ws.sv
// Directed bench for ram_ws: WAIT_STATES=2 instance for transfers, WAIT_STATES=0 for back-to-back.
module tb_ram_ws;
    import ram_pkg::*;

    localparam int unsigned AW = 9;

`ifdef RAM_ALIGN_CHECK_EN
    localparam logic        EXP_MIS_ERR = 1'b1;
    localparam logic [31:0] EXP_MIS_RD  = 32'hA5A5_A5A5;
    localparam logic [31:0] EXP_W004    = 32'h0000_0000;
    localparam logic [31:0] EXP_W008    = 32'h0000_0000;
`else
    localparam logic        EXP_MIS_ERR = 1'b0;
    localparam logic [31:0] EXP_MIS_RD  = 32'hFEBA_BE00;
    localparam logic [31:0] EXP_W004    = 32'h00CA_FEBA;
    localparam logic [31:0] EXP_W008    = 32'hBE00_0000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ram_ws_if #(.ADDR_WIDTH(AW)) bus ();
    ram_ws_if #(.ADDR_WIDTH(AW)) bus0 ();

    ram_ws #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ram_ws #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    // Present a request for one edge; returns just after the accepting edge.
    task automatic start_req(input logic rw, input logic [1:0] len, input logic [AW-1:0] a,
                             input logic [31:0] d);
        bus.enable = 1'b1; bus.read_write = rw; bus.data_length = len;
        bus.address = a; bus.data_in = d;
        @(posedge clk); #1;
        bus.enable = 1'b0;
    endtask

    // Count edges until mfc is seen (bounded), capturing data_out and err with it.
    task automatic wait_mfc(output int n, output logic [31:0] q, output logic e);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.mfc !== 1'b1 && n < 40);
        q = bus.data_out;
        e = bus.err;
    endtask

    // Single-beat access, then one edge so the FSM is back in IDLE.
    task automatic access(input logic rw, input logic [1:0] len, input logic [AW-1:0] a,
                          input logic [31:0] d, output int n, output logic [31:0] q,
                          output logic e);
        start_req(rw, len, a, d);
        wait_mfc(n, q, e);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        if (bus.data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
        vectors++;
        if (bus.mfc !== 1'b0) begin miscompares++; $display("FAIL reset_mfc: got %b want 0", bus.mfc); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++;
        if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.err); end
        vectors++;
    endtask

    task automatic test_word_byte;
        int n; logic [31:0] q; logic e;
        logic [7:0] exp_b [4];
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        access(RW_WRITE, LEN_WORD, 9'h010, 32'hDEAD_BEEF, n, q, e);
        if (n !== 3) begin miscompares++; $display("FAIL word_wr_latency: got %0d want 3", n); end
        vectors++;
        if (e !== 1'b0) begin miscompares++; $display("FAIL word_wr_err: got %b want 0", e); end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            access(RW_READ, LEN_BYTE, 9'h010 + AW'(i), 32'h0, n, q, e);
            if (q !== {24'h0, exp_b[i]}) begin miscompares++; $display("FAIL byte_rd_%0d: got %h want %h", i, q, {24'h0, exp_b[i]}); end
            vectors++;
            if (n !== 3) begin miscompares++; $display("FAIL byte_rd_latency_%0d: got %0d want 3", i, n); end
            vectors++;
        end
    endtask

    task automatic test_halfword;
        int n; logic [31:0] q; logic e;
        access(RW_WRITE, LEN_WORD, 9'h020, 32'h0, n, q, e);
        access(RW_WRITE, LEN_HALF, 9'h020, 32'hABCD_1234, n, q, e);
        if (bus.data_out !== 32'h0000_00EF) begin miscompares++; $display("FAIL dout_hold: got %h want 000000ef", bus.data_out); end
        vectors++;
        access(RW_READ, LEN_WORD, 9'h020, 32'h0, n, q, e);
        if (q !== 32'h1234_0000) begin miscompares++; $display("FAIL half_word_rd: got %h want 12340000", q); end
        vectors++;
        access(RW_READ, LEN_HALF, 9'h020, 32'h0, n, q, e);
        if (q !== 32'h0000_1234) begin miscompares++; $display("FAIL half_rd: got %h want 00001234", q); end
        vectors++;
    endtask

    task automatic test_dword;
        int n1, n2; logic [31:0] q1, q2; logic e;
        start_req(RW_WRITE, LEN_DWORD, 9'h1FC, 32'h1111_1111);
        wait_mfc(n1, q1, e);
        bus.data_in = 32'h2222_2222;
        wait_mfc(n2, q2, e);
        @(posedge clk); #1;
        if (n1 !== 3) begin miscompares++; $display("FAIL dw_wr_first: got %0d want 3", n1); end
        vectors++;
        if (n2 !== 4) begin miscompares++; $display("FAIL dw_wr_spacing: got %0d want 4", n2); end
        vectors++;
        access(RW_READ, LEN_WORD, 9'h1FC, 32'h0, n1, q1, e);
        if (q1 !== 32'h1111_1111) begin miscompares++; $display("FAIL dw_rd_1fc: got %h want 11111111", q1); end
        vectors++;
        access(RW_READ, LEN_WORD, 9'h000, 32'h0, n1, q1, e);
        if (q1 !== 32'h2222_2222) begin miscompares++; $display("FAIL dw_rd_000: got %h want 22222222", q1); end
        vectors++;
        start_req(RW_READ, LEN_DWORD, 9'h1FC, 32'h0);
        wait_mfc(n1, q1, e);
        wait_mfc(n2, q2, e);
        @(posedge clk); #1;
        if (q1 !== 32'h1111_1111) begin miscompares++; $display("FAIL dw_rd_hi: got %h want 11111111", q1); end
        vectors++;
        if (q2 !== 32'h2222_2222) begin miscompares++; $display("FAIL dw_rd_lo: got %h want 22222222", q2); end
        vectors++;
        if (n2 !== 4) begin miscompares++; $display("FAIL dw_rd_spacing: got %0d want 4", n2); end
        vectors++;
    endtask

    task automatic test_reset_abort;
        int n; logic [31:0] q; logic e;
        access(RW_WRITE, LEN_WORD, 9'h040, 32'hA5A5_A5A5, n, q, e);
        access(RW_READ, LEN_WORD, 9'h010, 32'h0, n, q, e);
        start_req(RW_WRITE, LEN_WORD, 9'h040, 32'h1234_5678);
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL busy_rise: got %b want 1", bus.busy); end
        vectors++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        if (bus.mfc !== 1'b0) begin miscompares++; $display("FAIL abort_mfc: got %b want 0", bus.mfc); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        vectors++;
        if (bus.data_out !== 32'h0) begin miscompares++; $display("FAIL abort_dout: got %h want 0", bus.data_out); end
        vectors++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(RW_READ, LEN_WORD, 9'h040, 32'h0, n, q, e);
        if (q !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL abort_mem: got %h want a5a5a5a5", q); end
        vectors++;
    endtask

    task automatic test_align;
        int n; logic [31:0] q; logic e;
        access(RW_WRITE, LEN_WORD, 9'h004, 32'h0, n, q, e);
        access(RW_WRITE, LEN_WORD, 9'h008, 32'h0, n, q, e);
        access(RW_WRITE, LEN_WORD, 9'h005, 32'hCAFE_BABE, n, q, e);
        if (n !== 3) begin miscompares++; $display("FAIL mis_wr_latency: got %0d want 3", n); end
        vectors++;
        if (e !== EXP_MIS_ERR) begin miscompares++; $display("FAIL mis_wr_err: got %b want %b", e, EXP_MIS_ERR); end
        vectors++;
        access(RW_READ, LEN_WORD, 9'h006, 32'h0, n, q, e);
        if (q !== EXP_MIS_RD) begin miscompares++; $display("FAIL mis_rd_data: got %h want %h", q, EXP_MIS_RD); end
        vectors++;
        if (e !== EXP_MIS_ERR) begin miscompares++; $display("FAIL mis_rd_err: got %b want %b", e, EXP_MIS_ERR); end
        vectors++;
        access(RW_READ, LEN_WORD, 9'h004, 32'h0, n, q, e);
        if (q !== EXP_W004) begin miscompares++; $display("FAIL mis_mem_004: got %h want %h", q, EXP_W004); end
        vectors++;
        access(RW_READ, LEN_WORD, 9'h008, 32'h0, n, q, e);
        if (q !== EXP_W008) begin miscompares++; $display("FAIL mis_mem_008: got %h want %h", q, EXP_W008); end
        vectors++;
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        logic exp_busy, exp_mfc;
        bus0.read_write = RW_WRITE; bus0.data_length = LEN_BYTE;
        bus0.address = 9'h000; bus0.data_in = 32'h0000_0055;
        bus0.enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            exp_busy = (i % 3) != 2;
            exp_mfc  = (i % 3) == 1;
            if (bus0.busy !== exp_busy) begin miscompares++; $display("FAIL b2b_busy_%0d: got %b want %b", i, bus0.busy, exp_busy); end
            vectors++;
            if (bus0.mfc !== exp_mfc) begin miscompares++; $display("FAIL b2b_mfc_%0d: got %b want %b", i, bus0.mfc, exp_mfc); end
            vectors++;
            if (bus0.mfc === 1'b1) pulses++;
        end
        bus0.enable = 1'b0;
        if (pulses !== 3) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        vectors++;
        bus0.read_write = RW_READ;
        bus0.enable = 1'b1;
        @(posedge clk); #1;
        bus0.enable = 1'b0;
        @(posedge clk); #1;
        if (bus0.mfc !== 1'b1) begin miscompares++; $display("FAIL ws0_latency: got mfc %b want 1", bus0.mfc); end
        vectors++;
        if (bus0.data_out !== 32'h0000_0055) begin miscompares++; $display("FAIL ws0_rd: got %h want 00000055", bus0.data_out); end
        vectors++;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.enable = 1'b0; bus.read_write = RW_READ; bus.data_length = LEN_BYTE;
        bus.address = '0; bus.data_in = '0;
        bus0.enable = 1'b0; bus0.read_write = RW_READ; bus0.data_length = LEN_BYTE;
        bus0.address = '0; bus0.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_word_byte;
        test_halfword;
        test_dword;
        test_reset_abort;
        test_align;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
